// File: rtl/jtopl_lfo.sv
// jtopl_lfo -- low-frequency oscillator for the OPL core.
//
// Counts output samples (tick = cenop & zero) and derives:
//   * am_mod  : tremolo attenuation offset (envelope LSBs, 0.1875 dB each),
//               a 210-step triangle scaled by the tremolo depth dam.
//   * vib_cnt : 3-bit vibrato phase position for the phase generator.
// All state is global (not per slot).
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   cenop     in   operator-rate clock enable
//   zero      in   high during the slot-0 cenop cycle
//   dam       in   tremolo depth: 1 = 4.8 dB, 0 = 1 dB
//   lfo_test  in   prescaler bypass, only honoured with JTOPL_LFO_TEST_EN
//   am_mod    out  [4:0] tremolo offset
//   vib_cnt   out  [2:0] vibrato position
//
// Configuration macro: JTOPL_LFO_TEST_EN
//   defined   -> lfo_test=1 makes every tick an AM and vibrato step, with
//                both prescalers holding their values meanwhile.
//   undefined -> lfo_test is ignored and the prescalers always run.

module jtopl_lfo (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic       zero,
  input  logic       dam,
  input  logic       lfo_test,
  output logic [4:0] am_mod,
  output logic [2:0] vib_cnt
);

  logic       tick;
  logic       bypass;
  logic       am_step;
  logic       vib_step;

  logic [5:0] am_div_q,  am_div_d;
  logic [9:0] vib_div_q, vib_div_d;
  logic [7:0] am_pos_q,  am_pos_d;
  logic [2:0] vib_cnt_q, vib_cnt_d;
  logic [4:0] am_mod_q,  am_mod_d;

  logic [7:0] am_mirror;
  logic [6:0] am_tri;

  assign tick = cenop & zero;

`ifdef JTOPL_LFO_TEST_EN
  assign bypass = lfo_test;
`else
  logic unused_lfo_test;
  assign unused_lfo_test = lfo_test;
  assign bypass          = 1'b0;
`endif

  assign am_step  = tick & (bypass | (am_div_q  == 6'd63));
  assign vib_step = tick & (bypass | (vib_div_q == 10'd1023));

  // Prescalers: free-running on ticks, frozen while bypassed.
  always_comb begin
    am_div_d  = am_div_q;
    vib_div_d = vib_div_q;
    if (tick && !bypass) begin
      am_div_d  = am_div_q  + 6'd1;
      vib_div_d = vib_div_q + 10'd1;
    end
  end

  // Waveform positions.
  always_comb begin
    am_pos_d  = am_pos_q;
    vib_cnt_d = vib_cnt_q;
    if (am_step)
      am_pos_d = (am_pos_q == 8'd209) ? '0 : am_pos_q + 8'd1;
    if (vib_step)
      vib_cnt_d = vib_cnt_q + 3'd1;
  end

  // Triangle: rises 0..104, then mirrors back down 104..0.
  assign am_mirror = 8'd209 - am_pos_q;

  always_comb begin
    am_tri = (am_pos_q < 8'd105) ? am_pos_q[6:0] : am_mirror[6:0];
    // Registered from am_pos_q and dam every clock, so any change shows up
    // exactly one clock later.
    am_mod_d = dam ? am_tri[6:2] : {2'b00, am_tri[6:4]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      am_div_q  <= '0;
      vib_div_q <= '0;
      am_pos_q  <= '0;
      vib_cnt_q <= '0;
      am_mod_q  <= '0;
    end else begin
      am_div_q  <= am_div_d;
      vib_div_q <= vib_div_d;
      am_pos_q  <= am_pos_d;
      vib_cnt_q <= vib_cnt_d;
      am_mod_q  <= am_mod_d;
    end
  end

  assign am_mod  = am_mod_q;
  assign vib_cnt = vib_cnt_q;

endmodule

// File: doc/jtopl_lfo.md
# jtopl_lfo

Low-frequency oscillator for the OPL core, upstream of `jtopl_eg` and the phase generator. It counts output samples, marked by `cenop & zero`. From that count it derives the tremolo (amplitude modulation) offset that the envelope stage adds to attenuation, and the 3-bit vibrato position used by the phase generator. All state is global; none of it is per slot.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `cenop`  in  1  operator-rate clock enable, from `jtopl_div`.
- `zero`  in  1  high during the slot-0 `cenop` cycle, from `jtopl_slot_cnt`.
- `dam`  in  1  tremolo depth. 1 selects 4.8 dB; 0 selects 1 dB.
- `lfo_test`  in  1  test-mode prescaler bypass. Ignored unless `JTOPL_LFO_TEST_EN` is defined.
- `am_mod`  out  5  tremolo attenuation offset in envelope LSBs (0.1875 dB per LSB).
- `vib_cnt`  out  3  vibrato phase position.

## Operation
- `tick = cenop & zero`. This is one pulse per output sample. No state changes on cycles where `tick=0`.
- Tremolo path:
  - `am_div` is a 6-bit prescaler. It increments on every tick and wraps from 63 to 0.
  - An AM step happens on the tick where `am_div==63`.
  - `am_pos` is 8 bits, range 0..209. It increments on each AM step and wraps from 209 to 0.
  - Triangle value `am_tri` is 7 bits: `am_pos` when `am_pos<105`, otherwise `209-am_pos`. This gives 0 up to 104, then 104 down to 0.
  - `am_mod = dam ? am_tri>>2 : am_tri>>4`. The range is 0..26 when `dam=1` and 0..6 when `dam=0`.
  - `am_mod` is registered and updates on the cycle after any change of `am_pos` or `dam`.
- Vibrato path:
  - `vib_div` is a 10-bit prescaler. It increments on every tick and wraps from 1023 to 0.
  - On the tick where `vib_div==1023`, `vib_cnt` increments and wraps from 7 to 0.
- Full periods:
  - Tremolo: 210×64 = 13440 samples, which is 3.70 Hz at 49716 Hz.
  - Vibrato: 8×1024 = 8192 samples, which is 6.07 Hz.
- The two prescalers are independent and are never cleared by anything other than `rst`.
- Simultaneous events: `rst` has priority over `tick`. An AM step and a vibrato step on the same tick are both applied.

## Timing
- Reset clears `am_div`, `vib_div`, `am_pos`, `vib_cnt` and `am_mod` to 0 in the clock after `rst` is sampled high.
- Reset in mid-period restarts both waveforms from phase 0.
- Latency:
  - `vib_cnt` changes on the clock edge that samples the qualifying tick.
  - `am_mod` changes exactly one clock later, because it is registered from `am_pos`.
- `dam` is sampled every clock, not only on ticks. A change reaches `am_mod` after 1 clock.
- Outputs are stable between ticks. The `jtopl_eg` pipeline may sample them at any slot.

## Configuration
- Macro `JTOPL_LFO_TEST_EN`.
- Defined: when `lfo_test=1`, both prescalers are bypassed. Every tick is then an AM step and a vibrato step, giving a 210-sample tremolo period and an 8-sample vibrato period. `am_div` and `vib_div` hold their values while `lfo_test=1`. Normal counting resumes from the held values when `lfo_test` returns to 0.
- Undefined: `lfo_test` has no effect, and the prescalers always run.

## Test plan
1. Reset, then run 64 ticks with `dam=1` → `am_pos=1` and `am_mod=0`. After 4×64 ticks, `am_mod=1`.
2. `dam=1`, run 104×64 ticks → `am_mod=26`. After 210×64 ticks total → `am_pos=0` and `am_mod=0`, confirming the wrap.
3. Hold `am_pos=104`, toggle `dam` to 0 → `am_mod=6` one clock later. Toggle back to 1 → `am_mod=26`.
4. Run 1024 ticks → `vib_cnt=1`. Run 8192 ticks → `vib_cnt=0`. With `cenop=1` and `zero=0` for 5000 cycles → no change on any output.
5. Assert `rst` at tick 5000, then release → every output is 0 next clock, and the next vibrato step lands at tick 1024 after release.
6. With `JTOPL_LFO_TEST_EN` defined and `lfo_test=1`: 8 ticks → `vib_cnt` wraps to 0, and 105 ticks → `am_mod=26` (with `dam=1`). Without the macro, the same stimulus gives `vib_cnt=0` and `am_mod=0` after 105 ticks.
